// File: rtl/stack_op_sequencer_pkg.sv
// Shared definitions for the PUSH/POP stack sequencer.
// Holds the op encoding, the FSM state type and the default SP register index and bounds.
package stack_pkg;

    // Operation encoding on cmd_op
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MEM  = 2'd2,
        WB   = 2'd3
    } state_e;

    // Defaults: SP lives in R3, the stack is empty at 255 and full at 128
    localparam int unsigned SP_IDX_DEF   = 3;
    localparam int unsigned SP_TOP_DEF   = 255;
    localparam int unsigned SP_FLOOR_DEF = 128;

endpackage

// File: rtl/stack_op_sequencer_if.sv
// Bus bundle between the stack sequencer and its environment.
// Groups the command handshake, register-file read/write ports, the memory port and the
// completion status.
//   master : the sequencer side (drives rf/mem requests, cmd_ready, done, err)
//   slave  : the environment side (drives commands, read data, mem_rdata, mem_ack)
interface stack_op_sequencer_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned RAW = 2
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_op;
    logic [RAW-1:0] cmd_reg;

    logic [RAW-1:0] rf_raddr1;
    logic [RAW-1:0] rf_raddr2;
    logic [DW-1:0]  rf_rdata1;
    logic [DW-1:0]  rf_rdata2;
    logic           rf_we;
    logic [RAW-1:0] rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic           rf_we2;
    logic [RAW-1:0] rf_waddr2;
    logic [DW-1:0]  rf_wdata2;

    logic           mem_req;
    logic           mem_we;
    logic [DW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;
    logic           mem_ack;

    logic           done;
    logic           err;

    modport master (
        input  cmd_valid, cmd_op, cmd_reg, rf_rdata1, rf_rdata2, mem_rdata, mem_ack,
        output cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               rf_we2, rf_waddr2, rf_wdata2, mem_req, mem_we, mem_addr, mem_wdata,
               done, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_reg, rf_rdata1, rf_rdata2, mem_rdata, mem_ack,
        input  cmd_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               rf_we2, rf_waddr2, rf_wdata2, mem_req, mem_we, mem_addr, mem_wdata,
               done, err
    );

endinterface

// File: rtl/stack_op_sequencer.sv
// Multi-cycle PUSH/POP controller working on a 4-entry register file and data memory.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : stack_op_sequencer_if.master (command handshake, rf ports, mem port, done/err)
// Flow: IDLE accepts a command, EXEC samples SP and the source register and checks bounds,
// MEM runs one memory transaction, WB commits SP (port 2) and POP data (port 1).
module stack_op_sequencer
    import stack_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned RAW      = 2,
    parameter int unsigned SP_IDX   = SP_IDX_DEF,
    parameter int unsigned SP_TOP   = SP_TOP_DEF,
    parameter int unsigned SP_FLOOR = SP_FLOOR_DEF
) (
    input  logic                clk,
    input  logic                rst,
    stack_op_sequencer_if.master bus
);

    localparam logic [RAW-1:0] L_SP_IDX = RAW'(SP_IDX);
    localparam logic [DW-1:0]  L_TOP    = DW'(SP_TOP);
    localparam logic [DW-1:0]  L_FLOOR  = DW'(SP_FLOOR);

    state_e         r_state;
    logic           r_op;
    logic [RAW-1:0] r_reg;
    logic [DW-1:0]  r_sp;
    logic [DW-1:0]  r_data;

    logic           w_bound_err;
    logic [DW-1:0]  w_sp_inc;
    logic [DW-1:0]  w_sp_dec;

    // Bounds are checked on the live SP read so the refusal is reported in EXEC itself
    assign w_bound_err = ((r_op == OP_PUSH) && (bus.rf_rdata1 == L_FLOOR)) ||
                         ((r_op == OP_POP)  && (bus.rf_rdata1 == L_TOP));
    assign w_sp_inc    = r_sp + DW'(1);
    assign w_sp_dec    = r_sp - DW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_PUSH;
            r_reg   <= '0;
            r_sp    <= '0;
            r_data  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op    <= bus.cmd_op;
                        r_reg   <= bus.cmd_reg;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_sp    <= bus.rf_rdata1;
                    r_data  <= bus.rf_rdata2;
                    r_state <= w_bound_err ? IDLE : MEM;
                end
                MEM: begin
                    if (bus.mem_ack) begin
                        // PUSH keeps its source data; only POP needs the read value
                        if (r_op == OP_POP) begin
                            r_data <= bus.mem_rdata;
                        end
                        r_state <= WB;
                    end
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from the state so reset drops them without waiting for a clock
    always_comb begin
        bus.cmd_ready = (r_state == IDLE);
        bus.rf_raddr1 = L_SP_IDX;
        bus.rf_raddr2 = r_reg;
        bus.rf_waddr2 = L_SP_IDX;
        bus.rf_we     = 1'b0;
        bus.rf_waddr  = '0;
        bus.rf_wdata  = '0;
        bus.rf_we2    = 1'b0;
        bus.rf_wdata2 = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;

        unique case (r_state)
            EXEC: begin
                bus.done = w_bound_err;
                bus.err  = w_bound_err;
            end
            MEM: begin
                bus.mem_req = 1'b1;
                if (r_op == OP_PUSH) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = r_sp;
                    bus.mem_wdata = r_data;
                end else begin
                    bus.mem_addr  = w_sp_inc;
                end
            end
            WB: begin
                bus.rf_we2    = 1'b1;
                bus.rf_wdata2 = (r_op == OP_PUSH) ? w_sp_dec : w_sp_inc;
                // POP into SP itself: the SP update on port 2 is the only write
                if ((r_op == OP_POP) && (r_reg != L_SP_IDX)) begin
                    bus.rf_we    = 1'b1;
                    bus.rf_waddr = r_reg;
                    bus.rf_wdata = r_data;
                end
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Multi-cycle controller that executes PUSH/POP stack operations on the 4-entry register file and data memory.
- Reads SP (R3) and the source register through the register file's async read ports, runs one memory transaction, then commits SP through write port 2 and the POP destination through write port 1.
- Sits beside the ID/EX stages; the pipeline stalls while cmd_ready is low.

Parameters:
- DW, 8, data/register width
- RAW, 2, register address width
- SP_IDX, 3, register index holding SP
- SP_TOP, 255, SP reset value (empty stack)
- SP_FLOOR, 128, lowest SP value at which PUSH is still refused (stack full)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  operation request
- cmd_ready  out  1  sequencer idle, accepts command
- cmd_op  in  1  0=PUSH, 1=POP
- cmd_reg  in  RAW  PUSH source / POP destination register
- rf_raddr1  out  RAW  read port 1 address (always SP_IDX)
- rf_raddr2  out  RAW  read port 2 address (latched cmd_reg)
- rf_rdata1  in  DW  SP value
- rf_rdata2  in  DW  source register value
- rf_we  out  1  write port 1 enable (POP data)
- rf_waddr  out  RAW  write port 1 address
- rf_wdata  out  DW  write port 1 data
- rf_we2  out  1  write port 2 enable (SP update)
- rf_waddr2  out  RAW  write port 2 address (SP_IDX)
- rf_wdata2  out  DW  new SP
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1=write (PUSH), 0=read (POP)
- mem_addr  out  DW  stack address
- mem_wdata  out  DW  PUSH data
- mem_rdata  in  DW  POP data, valid with mem_ack
- mem_ack  in  1  memory completion
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: 1=overflow/underflow, no state changed

Behaviour:
- Clocking and reset are fixed: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset (async, active-high): state=IDLE. All outputs are 0 except cmd_ready=1, rf_raddr1=SP_IDX, rf_waddr2=SP_IDX. Latched op, reg, sp and data are cleared.
- States: IDLE, EXEC, MEM, WB.
- IDLE: cmd_ready=1. cmd_valid&cmd_ready latches cmd_op and cmd_reg, then goes to EXEC. cmd_ready is 0 in every other state.
- EXEC (1 cycle): latch sp=rf_rdata1 and data=rf_rdata2.
  - PUSH with sp==SP_FLOOR: done=1, err=1, go to IDLE.
  - POP with sp==SP_TOP: done=1, err=1, go to IDLE.
  - Otherwise go to MEM.
- MEM:
  - mem_req=1.
  - PUSH: mem_we=1, mem_addr=sp, mem_wdata=data.
  - POP: mem_we=0, mem_addr=sp+1 (8-bit).
  - Outputs stay stable until mem_ack. On mem_ack, capture mem_rdata and go to WB.
  - mem_ack with mem_req low is ignored. Minimum 1 cycle in MEM.
- WB (1 cycle): rf_we2=1, rf_wdata2 = sp-1 (PUSH) or sp+1 (POP).
  - POP with reg!=SP_IDX: also rf_we=1, rf_waddr=reg, rf_wdata=captured data.
  - POP with reg==SP_IDX: rf_we is suppressed; the final SP is sp+1 (SP-update port wins).
  - PUSH with reg==SP_IDX pushes the pre-decrement SP.
  - done=1, err=0, go to IDLE.
- Latency with 0-wait memory (ack in first MEM cycle): accept@T, EXEC@T+1, MEM@T+2, WB/done@T+3. Writes land at the T+4 edge. Next command is accepted at T+4.
- Arithmetic: 8-bit modulo. The bounds checks ensure SP stays within SP_FLOOR..SP_TOP, so no wrap occurs in legal use.
- cmd_valid while busy is ignored; the requester holds it.
- Reset mid-operation (any state): immediate return to IDLE. mem_req, rf_we and rf_we2 drop asynchronously, no partial commit, no done.

Decomposition:
- Shared package stack_pkg holds:
  - op encoding OP_PUSH=0, OP_POP=1
  - state enum {IDLE, EXEC, MEM, WB}
  - SP_IDX, SP_TOP and SP_FLOOR defaults
- Single module, no sub-module. The FSM and datapath latches are small enough to live together.

Test Plan:
- R1=0x5A, SP=255, PUSH R1, 0-wait memory -> mem write addr 255 data 0x5A at T+2; SP=254 and done=1, err=0 at T+3; R1 unchanged.
- Continuing, POP R2 with mem_rdata=0x5A, ack delayed 3 cycles -> mem_req/addr 255 held 3 cycles; WB writes R2=0x5A, SP=255; cmd_ready low throughout.
- SP=255, POP R0 -> done=1, err=1 at T+1; no mem_req, no rf writes, R0 and SP unchanged.
- SP forced to 128, PUSH R0 -> err=1 at T+1, no mem_req, SP remains 128; SP=129 PUSH -> succeeds, SP=128.
- SP=200, POP R3 with mem_rdata=0x11 -> rf_we=0, rf_we2=1, SP=201.
- Assert rst during MEM (ack pending) -> mem_req=0 immediately, no rf write, done never pulses, cmd_ready=1 after release; SP unchanged.
